// File: rtl/scr1_ahb_sram_slave.sv
// scr1_ahb_sram_slave: AHB-Lite word-organised SRAM slave with wait states.
// Define SCR1_AHB_SRAM_ERR_EN to answer illegal transfers with ERROR.
module scr1_ahb_sram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [3:0]  hprot,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp
);

  localparam int AW = $clog2(MEM_WORDS);

`ifdef SCR1_AHB_SRAM_ERR_EN
  typedef enum logic [1:0] {
    ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE, ST_WAIT
  } state_t;
`endif

  logic [31:0]   mem [MEM_WORDS];
  state_t        state;
  logic [3:0]    cnt;
  logic          dp_act;
  logic          dp_write;
  logic          dp_ill;
  logic [AW-1:0] dp_idx;
  logic [1:0]    dp_lo;
  logic [1:0]    dp_size;
  logic          hready_r;
  logic [31:0]   hrdata_r;
  logic          accept;
  logic          a_ill;
  logic [AW-1:0] a_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_now;
  logic          rd_hit;
  logic [3:0]    wr_be;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign unused_ok = ^{hprot, hburst, hmastlock};

  assign accept = hready_r & hsel & htrans[1];
  assign a_idx  = haddr[AW+1:2];
  assign a_ill  = (hsize > 3'd2)
                | ((hsize == 3'd1) & haddr[0])
                | ((hsize == 3'd2) & (|haddr[1:0]))
                | (haddr[31:2] >= 30'(MEM_WORDS));

  assign wr_now = dp_act & hready_r & dp_write & ~dp_ill;

  always_comb begin
    wr_be = 4'b1111;
    case (dp_size)
      2'd0:    wr_be = 4'b0001 << dp_lo;
      2'd1:    wr_be = dp_lo[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  // zero-wait reads sample the array in the address phase, so a write
  // finishing on the same edge must be forwarded into the read word
  assign rd_idx = (WAIT_STATES == 0) ? a_idx : dp_idx;
  assign rd_hit = wr_now & (rd_idx == dp_idx);

  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++)
      if (rd_hit && wr_be[i])
        rd_word[8*i +: 8] = hwdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_now)
      for (int i = 0; i < 4; i++)
        if (wr_be[i])
          mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
  end

`ifdef SCR1_AHB_SRAM_ERR_EN
  logic hresp_r;
  assign hresp = hresp_r;
`else
  assign hresp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dp_act   <= 1'b0;
      dp_write <= 1'b0;
      dp_ill   <= 1'b0;
      dp_idx   <= '0;
      dp_lo    <= '0;
      dp_size  <= '0;
      hready_r <= 1'b1;
      hrdata_r <= '0;
`ifdef SCR1_AHB_SRAM_ERR_EN
      hresp_r  <= 1'b0;
`endif
    end else begin
      if (dp_act && hready_r)
        dp_act <= 1'b0;
      if (accept) begin
        dp_act   <= 1'b1;
        dp_write <= hwrite;
        dp_ill   <= a_ill;
        dp_idx   <= a_idx;
        dp_lo    <= haddr[1:0];
        dp_size  <= hsize[1:0];
        if (WAIT_STATES == 0) begin
          state    <= ST_IDLE;
          hready_r <= 1'b1;
          if (!hwrite)
            hrdata_r <= a_ill ? '0 : rd_word;
        end else begin
          state    <= ST_WAIT;
          cnt      <= 4'(WAIT_STATES);
          hready_r <= 1'b0;
        end
`ifdef SCR1_AHB_SRAM_ERR_EN
        hresp_r <= 1'b0;
        if (a_ill) begin
          dp_act   <= 1'b0;
          state    <= ST_ERR1;
          hready_r <= 1'b0;
          hresp_r  <= 1'b1;
          hrdata_r <= hrdata_r;
        end
`endif
      end else begin
        case (state)
          ST_WAIT: begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                hready_r <= 1'b1;
                if (!dp_write)
                  hrdata_r <= dp_ill ? '0 : rd_word;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
`ifdef SCR1_AHB_SRAM_ERR_EN
          ST_ERR1: begin
            state    <= ST_ERR2;
            hready_r <= 1'b1;
          end
          ST_ERR2: begin
            state   <= ST_IDLE;
            hresp_r <= 1'b0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign hready = hready_r;
  assign hrdata = hrdata_r;

endmodule

// File: tb/tb_scr1_ahb_sram_slave.sv
// tb_scr1_ahb_sram_slave: random AHB traffic checked against a byte model.
// Instance 0 runs WAIT_STATES=1, instance 1 runs WAIT_STATES=0.
module tb_scr1_ahb_sram_slave;

  localparam int MW = 1024;
`ifdef SCR1_AHB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit        idle;
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] data;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic [2:0]  hsize     [2];
  logic        hwrite    [2];
  logic [3:0]  hprot     [2];
  logic [2:0]  hburst    [2];
  logic        hmastlock [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic [31:0] hrdata    [2];
  logic        hresp     [2];

  bit [7:0]    mb [2][MW*4];
  tx_t         q[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] last_rd [2];
  bit          hold_ok [2];

  always #5 clk = ~clk;

  scr1_ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst[0]), .hsel(hsel[0]), .haddr(haddr[0]),
    .htrans(htrans[0]), .hsize(hsize[0]), .hwrite(hwrite[0]),
    .hprot(hprot[0]), .hburst(hburst[0]), .hmastlock(hmastlock[0]),
    .hwdata(hwdata[0]), .hready(hready[0]), .hrdata(hrdata[0]),
    .hresp(hresp[0])
  );

  scr1_ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[1]), .hsel(hsel[1]), .haddr(haddr[1]),
    .htrans(htrans[1]), .hsize(hsize[1]), .hwrite(hwrite[1]),
    .hprot(hprot[1]), .hburst(hburst[1]), .hmastlock(hmastlock[1]),
    .hwdata(hwdata[1]), .hready(hready[1]), .hrdata(hrdata[1]),
    .hresp(hresp[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit legal(input bit [31:0] a, input bit [2:0] s);
    int unsigned n;
    if (s > 3'd2) return 1'b0;
    n = 1 << s;
    if ((a % n) != 0) return 1'b0;
    return (a / 4) < MW;
  endfunction

  function automatic bit [31:0] mword(input int d, input bit [31:0] a);
    int unsigned b;
    b = (a / 4) * 4;
    return {mb[d][b+3], mb[d][b+2], mb[d][b+1], mb[d][b]};
  endfunction

  task automatic mwrite(input int d, input tx_t t);
    int unsigned n;
    int unsigned ba;
    n = 1 << t.size;
    for (int unsigned i = 0; i < n; i++) begin
      ba = t.addr + i;
      mb[d][ba] = t.data[8*(ba%4) +: 8];
    end
  endtask

  function automatic tx_t mk(input bit wr, input bit [31:0] a,
                             input bit [2:0] s, input bit [31:0] dat,
                             input bit [1:0] tr);
    tx_t t;
    t.idle = 1'b0;
    t.sel = 1'b1;
    t.trans = tr;
    t.wr = wr;
    t.addr = a;
    t.size = s;
    t.data = dat;
    return t;
  endfunction

  function automatic tx_t mk_idle();
    tx_t t;
    t = mk(1'($urandom), $urandom, 3'($urandom), 32'd0, 2'b00);
    t.idle = 1'b1;
    if ($urandom_range(0, 1) == 0) begin
      t.sel = 1'b0;
      t.trans = 2'($urandom);
    end else begin
      t.trans = 2'($urandom_range(0, 1));
    end
    return t;
  endfunction

  function automatic tx_t mk_rand();
    bit [31:0] a;
    bit [2:0]  s;
    int        k;
    int        k2;
    k = $urandom_range(0, 19);
    if (k < 14)      a = $urandom_range(0, 63);
    else if (k < 17) a = 32'(4*(MW-4)) + $urandom_range(0, 15);
    else if (k < 19) a = 32'(4*MW) + $urandom_range(0, 63);
    else             a = 32'h8000_0000 | $urandom;
    k2 = $urandom_range(0, 9);
    s = (k2 < 9) ? 3'(k2 % 3) : 3'($urandom_range(3, 7));
    return mk(1'($urandom), a, s, $urandom,
              ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
  endfunction

  task automatic drive_tx(input int d, input tx_t t);
    hsel[d] = t.sel;
    htrans[d] = t.trans;
    haddr[d] = t.addr;
    hsize[d] = t.size;
    hwrite[d] = t.wr;
    hprot[d] = 4'($urandom);
    hburst[d] = 3'($urandom);
    hmastlock[d] = 1'($urandom);
  endtask

  // address-phase noise while the slave stalls; it must be ignored
  task automatic drive_junk(input int d);
    tx_t t;
    t = mk(1'($urandom), $urandom_range(0, 63),
           3'($urandom_range(0, 2)), 32'd0, 2'($urandom));
    t.sel = 1'($urandom);
    drive_tx(d, t);
  endtask

  task automatic run_q(input int d);
    tx_t         cur;
    tx_t         nx;
    bit          have;
    bit          err;
    bit          done;
    int          c;
    int          guard;
    logic [31:0] exp;
    have = 1'b0;
    err = 1'b0;
    c = 0;
    guard = 0;
    cur = mk(1'b0, 32'd0, 3'd0, 32'd0, 2'b00);
    while ((q.size() != 0 || have) && guard < 5000) begin
      @(negedge clk);
      guard++;
      done = 1'b0;
      if (have) begin
        c++;
        hwdata[d] = cur.data;
        if (err) begin
          chk($sformatf("d%0d err hready", d), 32'(hready[d]), 32'(c == 2));
          chk($sformatf("d%0d err hresp", d), 32'(hresp[d]), 32'd1);
        end else begin
          chk($sformatf("d%0d hready", d), 32'(hready[d]),
              32'(c == ws(d) + 1));
          chk($sformatf("d%0d hresp", d), 32'(hresp[d]), 32'd0);
        end
        if (c > 20) begin
          chk($sformatf("d%0d timeout", d), 32'(c), 32'(ws(d) + 1));
          have = 1'b0;
          q.delete();
        end
      end else begin
        chk($sformatf("d%0d idle hready", d), 32'(hready[d]), 32'd1);
        chk($sformatf("d%0d idle hresp", d), 32'(hresp[d]), 32'd0);
      end
      if (have && hready[d]) begin
        done = 1'b1;
        if (err) begin
          hold_ok[d] = 1'b0;
        end else if (cur.wr) begin
          if (legal(cur.addr, cur.size)) mwrite(d, cur);
        end else begin
          exp = legal(cur.addr, cur.size) ? mword(d, cur.addr) : 32'd0;
          chk($sformatf("d%0d rdata @%h", d, cur.addr), hrdata[d], exp);
          last_rd[d] = exp;
          hold_ok[d] = 1'b1;
        end
        have = 1'b0;
      end
      if (!done && hold_ok[d] && !(have && err))
        chk($sformatf("d%0d hold", d), hrdata[d], last_rd[d]);
      if (hready[d]) begin
        if (q.size() != 0) begin
          nx = q.pop_front();
          drive_tx(d, nx);
          if (!nx.idle) begin
            cur = nx;
            have = 1'b1;
            c = 0;
            err = ERR_EN && !legal(nx.addr, nx.size);
          end
        end else begin
          drive_tx(d, mk_idle());
        end
      end else begin
        drive_junk(d);
      end
    end
    if (have || q.size() != 0) begin
      chk($sformatf("d%0d run budget", d), 32'(guard), 32'd0);
      q.delete();
    end
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    drive_tx(d, mk_idle());
    repeat (2) @(negedge clk);
    chk($sformatf("d%0d reset hready", d), 32'(hready[d]), 32'd1);
    chk($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'd0);
    chk($sformatf("d%0d reset hrdata", d), hrdata[d], 32'd0);
    rst[d] = 1'b0;
    last_rd[d] = 32'd0;
    hold_ok[d] = 1'b1;
  endtask

  task automatic rst_mid_write(input int d, input bit [31:0] a);
    @(negedge clk);
    drive_tx(d, mk(1'b1, a, 3'd2, 32'd0, 2'b10));
    @(negedge clk);
    hwdata[d] = ~mword(d, a);
    drive_tx(d, mk_idle());
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    chk($sformatf("d%0d midrst hready", d), 32'(hready[d]), 32'd1);
    chk($sformatf("d%0d midrst hresp", d), 32'(hresp[d]), 32'd0);
    chk($sformatf("d%0d midrst hrdata", d), hrdata[d], 32'd0);
    last_rd[d] = 32'd0;
    hold_ok[d] = 1'b1;
    q.push_back(mk(1'b0, a, 3'd2, 32'd0, 2'b10));
    run_q(d);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      drive_tx(d, mk_idle());
      hwdata[d] = 32'd0;
      last_rd[d] = 32'd0;
      hold_ok[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int w = 0; w < 16; w++)
        q.push_back(mk(1'b1, 32'(4*w), 3'd2, $urandom, 2'b10));
      for (int w = MW - 4; w < MW; w++)
        q.push_back(mk(1'b1, 32'(4*w), 3'd2, $urandom, 2'b10));
      run_q(d);
      q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10));
      q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0, 2'b10));
      q.push_back(mk(1'b1, 32'h10, 3'd2, 32'h0, 2'b10));
      q.push_back(mk(1'b1, 32'h13, 3'd0, 32'hA5A5A5A5, 2'b10));
      q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0, 2'b10));
      q.push_back(mk(1'b1, 32'h12, 3'd1, 32'h12341234, 2'b10));
      q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0, 2'b10));
      q.push_back(mk(1'b0, 32'h0, 3'd2, 32'd0, 2'b10));
      q.push_back(mk(1'b0, 32'h4, 3'd2, 32'd0, 2'b11));
      q.push_back(mk(1'b0, 32'h8, 3'd2, 32'd0, 2'b11));
      q.push_back(mk(1'b0, 32'hC, 3'd2, 32'd0, 2'b11));
      q.push_back(mk(1'b1, 32'h1, 3'd1, $urandom, 2'b10));
      q.push_back(mk(1'b0, 32'h0, 3'd2, 32'd0, 2'b10));
      q.push_back(mk(1'b0, 32'(4*MW), 3'd2, 32'd0, 2'b10));
      q.push_back(mk(1'b0, 32'h0, 3'd2, 32'd0, 2'b10));
      run_q(d);
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 9) < 3) q.push_back(mk_idle());
        else q.push_back(mk_rand());
      end
      run_q(d);
      rst_mid_write(d, 32'h8);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
